// File: rtl/sr_pkg.sv
// Shared types and counter widths for the S/R pulse driver and its debouncers.
package sr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PULSE_S = 2'b01,
      PULSE_R = 2'b10,
      GAP     = 2'b11
   } state_t;

   localparam int DB_W = 8;
   localparam int PL_W = 4;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button;
// emits a one-cycle registered pulse when the debounced level rises.
module btn_debounce
   import sr_pkg::*;
#(
   parameter int DEBOUNCE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE - 1);

   logic            sync1;
   logic            sync2;
   logic            level;
   logic [DB_W-1:0] cnt;

   // NOTE: every register here uses <= so all flops sample the pre-edge
   // values; blocking assignments would collapse the synchroniser chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt >= LAST) begin
            // The sample just matched for the DEBOUNCE-th consecutive time.
            level <= sync2;
            rise  <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_pulse_driver.sv
// Turns debounced set/reset button presses into non-overlapping active-low
// pulses for a NAND latch. Define SR_PULSE_DRIVER_FEEDBACK_EN to add the Q input.
module sr_pulse_driver
   import sr_pkg::*;
#(
   parameter int DEBOUNCE  = 8,
   parameter int PULSE_LEN = 2,
   parameter int GAP_LEN   = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_S,
   input  logic BTN_R,
`ifdef SR_PULSE_DRIVER_FEEDBACK_EN
   input  logic Q,
`endif
   output logic S,
   output logic R,
   output logic BUSY
);

   localparam logic [PL_W-1:0] PL_LAST  = PL_W'(PULSE_LEN - 1);
   localparam logic [PL_W-1:0] GAP_LAST = PL_W'(GAP_LEN - 1);

   state_t          state, state_nxt;
   logic [PL_W-1:0] cnt, cnt_nxt;
   logic            rise_s, rise_r;
   logic            pend_s, pend_r;
   logic            req_s, req_r;
   logic            ok_s, ok_r;
   logic            clr_s, clr_r;
   logic            arb;

   btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_s (
      .clk  (CLK),
      .rst  (RST),
      .btn  (BTN_S),
      .rise (rise_s)
   );

   btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_r (
      .clk  (CLK),
      .rst  (RST),
      .btn  (BTN_R),
      .rise (rise_r)
   );

   // A fresh edge is served in the same cycle it arrives, saving one cycle.
   assign req_s = pend_s | rise_s;
   assign req_r = pend_r | rise_r;

`ifdef SR_PULSE_DRIVER_FEEDBACK_EN
   logic q_meta, q_sync;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_meta <= 1'b0;
         q_sync <= 1'b0;
      end else begin
         q_meta <= Q;
         q_sync <= q_meta;
      end
   end

   assign ok_s = req_s & ~q_sync;
   assign ok_r = req_r &  q_sync;
`else
   assign ok_s = req_s;
   assign ok_r = req_r;
`endif

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_s     = 1'b0;
      clr_r     = 1'b0;
      arb       = 1'b0;
      case (state)
         IDLE: arb = 1'b1;
         PULSE_S, PULSE_R: begin
            if (cnt >= PL_LAST) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt >= GAP_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               arb       = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Ending GAP arbitrates like IDLE, so back-to-back pulses are GAP_LEN apart.
      if (arb) begin
         cnt_nxt = '0;
         if (ok_r) begin
            state_nxt = PULSE_R;
            clr_r     = 1'b1;
         end else if (ok_s) begin
            state_nxt = PULSE_S;
            clr_s     = 1'b1;
         end
`ifdef SR_PULSE_DRIVER_FEEDBACK_EN
         if (req_r && !ok_r) clr_r = 1'b1;
         if (req_s && !ok_s) clr_s = 1'b1;
`endif
      end
   end

   // Outputs are decoded from the next state and registered, so they never glitch.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= '0;
         pend_s <= 1'b0;
         pend_r <= 1'b0;
         S      <= 1'b1;
         R      <= 1'b1;
         BUSY   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         pend_s <= req_s & ~clr_s;
         pend_r <= req_r & ~clr_r;
         S      <= (state_nxt != PULSE_S);
         R      <= (state_nxt != PULSE_R);
         BUSY   <= (state_nxt != IDLE);
      end
   end

endmodule
